// File: rtl/sw_db_pkg.sv
// Shared types and defaults for the slide-switch debouncer.
package sw_db_pkg;

  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t;

  localparam int DB_CYCLES_DEF = 2_000_000;

endpackage

// File: rtl/sw_db_bit.sv
// Single-bit conditioner: 2-FF synchronizer, debounce FSM and hold counter.
// Emits the committed level plus one-cycle rise/fall commit strobes.
module sw_db_bit
  import sw_db_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [1:0]    sync;
  logic          s;
  db_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          level_nxt, rise_nxt, fall_nxt;

  assign s = sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      state <= ZERO;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // Counter is reloaded on every WAIT entry, so a bounce back simply leaves it stale.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    unique case (state)
      ZERO: if (s) begin
        state_nxt = WAIT1;
        cnt_nxt   = CW'(DB_CYCLES - 1);
      end
      WAIT1: begin
        if (!s) begin
          state_nxt = ZERO;
        end else if (cnt == '0) begin
          state_nxt = ONE;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ONE: if (!s) begin
        state_nxt = WAIT0;
        cnt_nxt   = CW'(DB_CYCLES - 1);
      end
      WAIT0: begin
        if (s) begin
          state_nxt = ONE;
        end else if (cnt == '0) begin
          state_nxt = ZERO;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = ZERO;
    endcase
  end

endmodule

// File: rtl/sw_debounce.sv
// W-bit slide-switch debouncer feeding the decoder's a/en inputs.
// Define SW_DB_EDGE_EN to expose per-bit sw_rise/sw_fall commit strobes.
module sw_debounce
  import sw_db_pkg::*;
#(
  parameter int W         = 4,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sw_raw,
  output logic [W-1:0] sw_db,
  output logic         sw_chg
`ifdef SW_DB_EDGE_EN
  ,
  output logic [W-1:0] sw_rise,
  output logic [W-1:0] sw_fall
`endif
);

  logic [W-1:0] rise_w, fall_w;

  for (genvar g = 0; g < W; g++) begin : g_bit
    sw_db_bit #(.DB_CYCLES(DB_CYCLES)) u_bit (
      .clk   (clk),
      .reset (reset),
      .raw   (sw_raw[g]),
      .level (sw_db[g]),
      .rise  (rise_w[g]),
      .fall  (fall_w[g])
    );
  end

  // Strobes are already registered, so the OR lands on the same edge as sw_db.
  assign sw_chg = |(rise_w | fall_w);

`ifdef SW_DB_EDGE_EN
  assign sw_rise = rise_w;
  assign sw_fall = fall_w;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce (W=4, DB_CYCLES=8); honours SW_DB_EDGE_EN.
module tb_sw_debounce;

  localparam int W   = 4;
  localparam int DB  = 8;
  localparam int LAT = DB + 3;

  typedef struct {
    int         cyc;
    logic [3:0] db;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_db;
  logic         sw_chg;
`ifdef SW_DB_EDGE_EN
  logic [W-1:0] sw_rise, sw_fall;
`endif

  sw_debounce #(.W(W), .DB_CYCLES(DB)) dut (
    .clk    (clk),
    .reset  (reset),
    .sw_raw (sw_raw),
    .sw_db  (sw_db),
    .sw_chg (sw_chg)
`ifdef SW_DB_EDGE_EN
    ,
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
`endif
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];
  exp_t mon_e;
  logic [W-1:0] prev_db = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every sw_chg pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (sw_chg) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_chg: sw_db=%0h with nothing pending (cycle %0d)", sw_db, cyc);
        end else begin
          mon_e = q.pop_front();
          chk("commit_cycle", cyc, mon_e.cyc);
          chk("sw_db", {28'd0, sw_db}, {28'd0, mon_e.db});
`ifdef SW_DB_EDGE_EN
          chk("sw_rise", {28'd0, sw_rise}, {28'd0, mon_e.rise});
          chk("sw_fall", {28'd0, sw_fall}, {28'd0, mon_e.fall});
`endif
        end
      end else if (sw_db !== prev_db) begin
        total++;
        $display("FAIL silent_change: sw_db %0h -> %0h without sw_chg (cycle %0d)", prev_db, sw_db, cyc);
      end
    end
    prev_db = sw_db;
  end

  task automatic expect_commit(input logic [3:0] db, input logic [3:0] rise, input logic [3:0] fall);
    exp_t e;
    e.cyc  = cyc + LAT;
    e.db   = db;
    e.rise = rise;
    e.fall = fall;
    q.push_back(e);
  endtask

  task automatic apply(input logic [3:0] v, input logic [3:0] db,
                       input logic [3:0] rise, input logic [3:0] fall);
    sw_raw = v;
    expect_commit(db, rise, fall);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      $display("FAIL %s_timeout: %0d commits still pending", name, q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // 1: reset held with all switches high
    reset  = 1'b1;
    sw_raw = 4'hF;
    repeat (4) begin
      @(negedge clk);
      chk("reset_sw_db", {28'd0, sw_db}, 32'h0);
      chk("reset_sw_chg", {31'd0, sw_chg}, 32'h0);
    end
    reset  = 1'b0;
    mon_en = 1'b1;
    expect_commit(4'hF, 4'hF, 4'h0);
    drain("t1");

    // 2: single bit rise
    apply(4'h0, 4'h0, 4'h0, 4'hF);
    drain("t2_clear");
    apply(4'h1, 4'h1, 4'h1, 4'h0);
    drain("t2");

    // 3: bit 2 bounces with 3-cycle pulses, then settles high
    sw_raw = 4'h5; repeat (3) @(negedge clk);
    sw_raw = 4'h1; repeat (3) @(negedge clk);
    sw_raw = 4'h5; repeat (3) @(negedge clk);
    sw_raw = 4'h1; repeat (3) @(negedge clk);
    chk("bounce_hold", {28'd0, sw_db}, 32'h1);
    apply(4'h5, 4'h5, 4'h4, 4'h0);
    drain("t3");

    // 4: several bits change together
    apply(4'h0, 4'h0, 4'h0, 4'h5);
    drain("t4_clear");
    apply(4'hA, 4'hA, 4'hA, 4'h0);
    drain("t4");

    // 5: reset aborts a wait in progress
    apply(4'h0, 4'h0, 4'h0, 4'hA);
    drain("t5_clear");
    sw_raw = 4'h2;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_sw_db", {28'd0, sw_db}, 32'h0);
    expect_commit(4'h2, 4'h2, 4'h0);
    drain("t5");

    // 6: one-cycle glitch on bit 3
    apply(4'h0, 4'h0, 4'h0, 4'h2);
    drain("t6_clear");
    sw_raw = 4'h8;
    @(negedge clk);
    sw_raw = 4'h0;
    repeat (20) begin
      @(negedge clk);
      chk("glitch_sw_db", {28'd0, sw_db}, 32'h0);
      chk("glitch_sw_chg", {31'd0, sw_chg}, 32'h0);
`ifdef SW_DB_EDGE_EN
      chk("glitch_rise_fall", {24'd0, sw_rise, sw_fall}, 32'h0);
`endif
    end

    chk("pending_left", q.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
